alsu_pipe: RTL

//   Parametrised, pipelined arithmetic-logic-shift unit. Next generation of the 3-bit ALSU.

---
 rtl/alsu_if.sv | 43 ++++
 rtl/alsu_pipe.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alsu_if.sv
// Operand/control request bus and result/status bus of the pipelined ALSU.
// err_cnt exists only when ALSU_ERR_CNT_EN is defined.
interface alsu_if #(
  parameter int WIDTH = 3,
  parameter int LED_W = 16
);
  logic                 in_valid;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [2:0]           opcode;
  logic                 cin;
  logic                 serial_in;
  logic                 direction;
  logic                 red_op_A;
  logic                 red_op_B;
  logic                 bypass_A;
  logic                 bypass_B;
  logic                 out_valid;
  logic [2*WIDTH-1:0]   out;
  logic [LED_W-1:0]     leds;
  logic                 err;
`ifdef ALSU_ERR_CNT_EN
  logic [7:0]           err_cnt;
`endif

  modport master (
    output in_valid, A, B, opcode, cin, serial_in, direction,
           red_op_A, red_op_B, bypass_A, bypass_B,
    input  out_valid, out, leds, err
`ifdef ALSU_ERR_CNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  in_valid, A, B, opcode, cin, serial_in, direction,
           red_op_A, red_op_B, bypass_A, bypass_B,
    output out_valid, out, leds, err
`ifdef ALSU_ERR_CNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/alsu_pipe.sv
// Two-stage valid-qualified arithmetic/logic/shift unit with error flag and LED toggle.
// Optional saturating invalid-operation counter compiled in with ALSU_ERR_CNT_EN.
module alsu_pipe #(
  parameter int WIDTH          = 3,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int LED_W          = 16
) (
  input  logic   clk,
  input  logic   rst,
  alsu_if.slave  bus
);
  localparam int OUT_W = 2 * WIDTH;

  // Selects operand B when only B is requested, or both are and B has priority.
  function automatic logic pick_b(input logic use_a, input logic use_b);
    return use_b && !(use_a && (INPUT_PRIORITY == "A"));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [2:0]       opcode_p1;
  logic             cin_p1;
  logic             serial_p1;
  logic             dir_p1;
  logic             red_a_p1;
  logic             red_b_p1;
  logic             byp_a_p1;
  logic             byp_b_p1;

  logic             vld_p2;
  logic [OUT_W-1:0] out_p2;
  logic [LED_W-1:0] leds_p2;
  logic             err_p2;

  logic             bypass;
  logic             invalid;
  logic             cin_eff;
  logic [WIDTH-1:0] red_src;
  logic [WIDTH:0]   sum;
  logic [OUT_W-1:0] result;

  // Stage 1: capture request; a request coinciding with rst is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      a_p1      <= bus.A;
      b_p1      <= bus.B;
      opcode_p1 <= bus.opcode;
      cin_p1    <= bus.cin;
      serial_p1 <= bus.serial_in;
      dir_p1    <= bus.direction;
      red_a_p1  <= bus.red_op_A;
      red_b_p1  <= bus.red_op_B;
      byp_a_p1  <= bus.bypass_A;
      byp_b_p1  <= bus.bypass_B;
    end
  end

  // Stage 2: compute result; SHIFT/ROTATE operate on the registered out so they chain
  always_comb begin
    bypass  = byp_a_p1 | byp_b_p1;
    invalid = (opcode_p1[2:1] == 2'b11) ||
              ((red_a_p1 | red_b_p1) && (opcode_p1 inside {[3'b010:3'b101]}));
    cin_eff = (FULL_ADDER == "ON") ? cin_p1 : 1'b0;
    sum     = (WIDTH+1)'(a_p1) + (WIDTH+1)'(b_p1) + (WIDTH+1)'(cin_eff);
    red_src = '0;
    result  = '0;
    if (bypass) begin
      result = OUT_W'(pick_b(byp_a_p1, byp_b_p1) ? b_p1 : a_p1);
    end else if (!invalid) begin
      case (opcode_p1)
        3'b000, 3'b001: begin
          if (!(red_a_p1 | red_b_p1)) begin
            result = OUT_W'(opcode_p1[0] ? (a_p1 ^ b_p1) : (a_p1 & b_p1));
          end else begin
            red_src = pick_b(red_a_p1, red_b_p1) ? b_p1 : a_p1;
            result  = OUT_W'(opcode_p1[0] ? ^red_src : &red_src);
          end
        end
        3'b010:  result = OUT_W'(sum);
        3'b011:  result = OUT_W'(a_p1) * OUT_W'(b_p1);
        3'b100:  result = dir_p1 ? {out_p2[OUT_W-2:0], serial_p1}
                                 : {serial_p1, out_p2[OUT_W-1:1]};
        3'b101:  result = dir_p1 ? {out_p2[OUT_W-2:0], out_p2[OUT_W-1]}
                                 : {out_p2[0], out_p2[OUT_W-1:1]};
        default: result = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      out_p2  <= '0;
      leds_p2 <= '0;
      err_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_p2 <= result;
        err_p2 <= !bypass && invalid;
        if (!bypass && invalid) begin
          leds_p2 <= ~leds_p2;
        end
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out       = out_p2;
  assign bus.leds      = leds_p2;
  assign bus.err       = err_p2;

`ifdef ALSU_ERR_CNT_EN
  logic [7:0] err_cnt_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_p2 <= 8'd0;
    end else if (vld_p1 && !bypass && invalid) begin
      err_cnt_p2 <= sat_inc8(err_cnt_p2);
    end
  end

  assign bus.err_cnt = err_cnt_p2;
`endif
endmodule
